// File: rtl/mod12_count_monitor_if.sv
// Beat and result bundle between a mod-12 stream tap and its monitor.
// Ports: beat fields (valid, load, mode, data_in, count, err_clear) and
//   monitor results (locked, expected, pulses, err_count); the master
//   drives beats, the slave is the monitor.
interface mod12_count_monitor_if #(
   parameter int ERR_W = 8
);
   logic             valid;
   logic             load;
   logic             mode;
   logic [3:0]       data_in;
   logic [3:0]       count;
   logic             err_clear;
   logic             locked;
   logic [3:0]       expected;
   logic             mismatch;
   logic             range_err;
   logic             wrap_up;
   logic             wrap_down;
   logic [ERR_W-1:0] err_count;

   modport master (
      output valid, load, mode, data_in, count, err_clear,
      input  locked, expected, mismatch, range_err,
      input  wrap_up, wrap_down, err_count
   );

   modport slave (
      input  valid, load, mode, data_in, count, err_clear,
      output locked, expected, mismatch, range_err,
      output wrap_up, wrap_down, err_count
   );
endinterface

// File: rtl/mod12_count_monitor.sv
// Receive-side checker for a mod-12 up/down/loadable count stream.
// Ports: clock, reset (sync, active-high), bus (slave modport): beats in,
//   registered lock/prediction/pulse/error-tally results out.
module mod12_count_monitor #(
   parameter int LOSS_THRESH = 3,
   parameter int ERR_W       = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   mod12_count_monitor_if.slave bus
);

   typedef enum logic {
      UNSYNC = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
   localparam logic [4:0]       THRESH  = 5'(LOSS_THRESH);

   state_t           state_q, state_d;
   logic [3:0]       ref_q, ref_d;
   logic [3:0]       miss_q, miss_d;
   logic [3:0]       exp_q, exp_d;
   logic             mis_q, mis_d;
   logic             rng_q, rng_d;
   logic             wup_q, wup_d;
   logic             wdn_q, wdn_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic [3:0]       pred;
   logic             hit;
   logic             out_of_range;
   logic [4:0]       miss_inc;

   // Prediction from the last accepted value; an out-of-range ref
   // steps to 0 going up and to 11 going down.
   always_comb begin
      if (bus.load) begin
         pred = bus.data_in;
      end else if (!bus.mode) begin
         pred = (ref_q >= 4'd11) ? 4'd0 : ref_q + 4'd1;
      end else begin
         pred = (ref_q == 4'd0 || ref_q > 4'd11) ? 4'd11 : ref_q - 4'd1;
      end
   end

   assign hit          = (bus.count == pred);
   assign out_of_range = (bus.count > 4'd11)
                       || (bus.load && bus.data_in > 4'd11);
   assign miss_inc     = {1'b0, miss_q} + 5'd1;

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      miss_d  = miss_q;
      exp_d   = exp_q;
      mis_d   = 1'b0;
      rng_d   = 1'b0;
      wup_d   = 1'b0;
      wdn_d   = 1'b0;
      err_d   = err_q;

      if (bus.valid) begin
         rng_d = out_of_range;

         unique case (state_q)
            UNSYNC: begin
               exp_d = bus.count;
               if (bus.count <= 4'd11) begin
                  ref_d   = bus.count;
                  miss_d  = 4'd0;
                  state_d = LOCKED;
               end
            end

            LOCKED: begin
               exp_d = pred;
               // Always resync to the observed value so a single
               // fault is counted once, not on every later beat.
               ref_d = bus.count;
               if (hit) begin
                  miss_d = 4'd0;
                  wup_d  = !bus.load && !bus.mode
                         && ref_q == 4'd11 && bus.count == 4'd0;
                  wdn_d  = !bus.load && bus.mode
                         && ref_q == 4'd0 && bus.count == 4'd11;
               end else begin
                  mis_d = 1'b1;
                  if (miss_inc >= THRESH) begin
                     miss_d  = 4'd0;
                     state_d = UNSYNC;
                  end else begin
                     miss_d = miss_inc[3:0];
                  end
               end
            end

            default: state_d = UNSYNC;
         endcase

         // A clear coinciding with a mismatch keeps that mismatch.
         if (bus.err_clear) begin
            err_d = mis_d ? ERR_ONE : '0;
         end else if (mis_d && err_q != ERR_MAX) begin
            err_d = err_q + ERR_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= UNSYNC;
         ref_q   <= 4'd0;
         miss_q  <= 4'd0;
         exp_q   <= 4'd0;
         mis_q   <= 1'b0;
         rng_q   <= 1'b0;
         wup_q   <= 1'b0;
         wdn_q   <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         miss_q  <= miss_d;
         exp_q   <= exp_d;
         mis_q   <= mis_d;
         rng_q   <= rng_d;
         wup_q   <= wup_d;
         wdn_q   <= wdn_d;
         err_q   <= err_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.expected  = exp_q;
   assign bus.mismatch  = mis_q;
   assign bus.range_err = rng_q;
   assign bus.wrap_up   = wup_q;
   assign bus.wrap_down = wdn_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Scoreboard bench for mod12_count_monitor with hand-computed vectors.
// Ports: none; drives the DUT through a master-side interface instance.
module tb_mod12_count_monitor;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   mod12_count_monitor_if #(.ERR_W(2)) bus ();

   mod12_count_monitor #(
      .LOSS_THRESH(3),
      .ERR_W      (2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      int         due;
      logic       l;
      logic [3:0] e;
      logic       m;
      logic       r;
      logic       wu;
      logic       wd;
      logic [1:0] ec;
      string      nm;
   } exp_t;

   exp_t q[$];
   exp_t mx;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: compares the entry whose sampling edge has just passed.
   always @(negedge clock) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         mx = q.pop_front();
         checks++;
         if ({bus.locked, bus.expected, bus.mismatch, bus.range_err,
              bus.wrap_up, bus.wrap_down, bus.err_count} !==
             {mx.l, mx.e, mx.m, mx.r, mx.wu, mx.wd, mx.ec}) begin
            failures++;
            $display("FAIL %s got l=%0d e=%0d m=%0d r=%0d wu=%0d wd=%0d ec=%0d want l=%0d e=%0d m=%0d r=%0d wu=%0d wd=%0d ec=%0d",
                     mx.nm, bus.locked, bus.expected, bus.mismatch,
                     bus.range_err, bus.wrap_up, bus.wrap_down,
                     bus.err_count, mx.l, mx.e, mx.m, mx.r, mx.wu,
                     mx.wd, mx.ec);
         end
      end
   end

   task automatic step(
      input logic       rs, v, ld, md,
      input logic [3:0] d, c,
      input logic       clr,
      input logic       el,
      input logic [3:0] ee,
      input logic       em, er, ewu, ewd,
      input logic [1:0] ec,
      input string      nm
   );
      exp_t x;
      @(posedge clock);
      #1;
      reset         = rs;
      bus.valid     = v;
      bus.load      = ld;
      bus.mode      = md;
      bus.data_in   = d;
      bus.count     = c;
      bus.err_clear = clr;
      x.due = cyc + 1;
      x.l   = el;
      x.e   = ee;
      x.m   = em;
      x.r   = er;
      x.wu  = ewu;
      x.wd  = ewd;
      x.ec  = ec;
      x.nm  = nm;
      q.push_back(x);
   endtask

   initial begin
      bus.valid     = 1'b0;
      bus.load      = 1'b0;
      bus.mode      = 1'b0;
      bus.data_in   = 4'd0;
      bus.count     = 4'd0;
      bus.err_clear = 1'b0;

      //   rs v ld md d  c  clr  l  e  m r wu wd ec
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,0,0,0,0, "reset");
      // acquire and up-count through wrap
      step(0, 1, 0, 0, 0, 9, 0,  1, 9, 0,0,0,0,0, "acq9");
      step(0, 1, 0, 0, 0,10, 0,  1,10, 0,0,0,0,0, "up10");
      step(0, 1, 0, 0, 0,11, 0,  1,11, 0,0,0,0,0, "up11");
      step(0, 1, 0, 0, 0, 0, 0,  1, 0, 0,0,1,0,0, "wrap_up");
      step(0, 1, 0, 0, 0, 1, 0,  1, 1, 0,0,0,0,0, "up1");
      // down wrap and load
      step(0, 1, 0, 1, 0, 0, 0,  1, 0, 0,0,0,0,0, "dn0");
      step(0, 1, 0, 1, 0,11, 0,  1,11, 0,0,0,1,0, "wrap_down");
      step(0, 1, 0, 1, 0,10, 0,  1,10, 0,0,0,0,0, "dn10");
      step(0, 1, 1, 0, 5, 5, 0,  1, 5, 0,0,0,0,0, "load5");
      step(0, 1, 0, 1, 0, 5, 0,  1, 4, 1,0,0,0,1, "dn_mis");
      // loss of lock
      step(0, 1, 0, 1, 0, 4, 1,  1, 4, 0,0,0,0,0, "clr_at4");
      step(0, 1, 0, 0, 0, 7, 0,  1, 5, 1,0,0,0,1, "miss1");
      step(0, 1, 0, 0, 0, 2, 0,  1, 8, 1,0,0,0,2, "miss2");
      step(0, 1, 0, 0, 0, 9, 0,  0, 3, 1,0,0,0,3, "miss3_loss");
      step(0, 1, 0, 0, 0, 3, 0,  1, 3, 0,0,0,0,3, "relock");
      // range errors
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,0,0,0,0, "reset2");
      step(0, 1, 0, 0, 0,13, 0,  0,13, 0,1,0,0,0, "rng_unsync");
      step(0, 1, 0, 0, 0,11, 0,  1,11, 0,0,0,0,0, "acq11");
      step(0, 1, 1, 0,14,14, 0,  1,14, 0,1,0,0,0, "rng_load14");
      step(0, 1, 0, 0, 0, 0, 0,  1, 0, 0,0,0,0,0, "up_from14");
      // saturation and clear
      step(0, 1, 0, 0, 0, 5, 0,  1, 1, 1,0,0,0,1, "sat1");
      step(0, 1, 0, 0, 0, 5, 0,  1, 6, 1,0,0,0,2, "sat2");
      step(0, 1, 0, 0, 0, 5, 0,  0, 6, 1,0,0,0,3, "sat3");
      step(0, 1, 0, 0, 0, 5, 0,  1, 5, 0,0,0,0,3, "sat_acq");
      step(0, 1, 0, 0, 0, 9, 0,  1, 6, 1,0,0,0,3, "sat4");
      step(0, 1, 0, 0, 0, 9, 0,  1,10, 1,0,0,0,3, "sat5");
      step(0, 1, 0, 0, 0, 2, 1,  0,10, 1,0,0,0,1, "clr_mis");
      step(0, 1, 0, 0, 0, 4, 1,  1, 4, 0,0,0,0,0, "clr_only");
      // idle with junk on the beat fields
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, 1,14,15, 0, 1, 4, 0,0,0,0,0, "idle");
      step(0, 1, 0, 0, 0, 5, 0,  1, 5, 0,0,0,0,0, "post_idle");
      // reset mid-stream and re-acquire
      step(1, 1, 0, 0, 0, 6, 0,  0, 0, 0,0,0,0,0, "reset3");
      step(0, 1, 0, 1, 0, 7, 0,  1, 7, 0,0,0,0,0, "reacq7");
      step(0, 1, 0, 1, 0, 6, 0,  1, 6, 0,0,0,0,0, "dn6");

      @(posedge clock);
      #1;
      bus.valid = 1'b0;
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         @(negedge clock);
         #1;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mod12_count_monitor.md
# mod12_count_monitor

Checking block on the receive side of a mod-12 up/down/loadable count stream. Each valid beat carries the counter's control inputs for one edge and the count value produced by that edge. The block predicts each next value, flags mismatches, range errors and wrap events, and reports lock status plus a saturating error tally. It sits downstream of mod-12 sequence sources, for in-system self-check and for driving bench scoreboards.

## Interface
Parameters:
- LOSS_THRESH, 3: number of consecutive mismatching beats in LOCKED that forces a return to UNSYNC; legal range 1..15.
- ERR_W, 8: width of err_count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  beat qualifier; all other inputs are ignored when low.
- load  in  1  load was applied at the observed edge.
- mode  in  1  0 = up step, 1 = down step; ignored when load=1.
- data_in  in  4  load value applied at the observed edge.
- count  in  4  counter output after the observed edge.
- err_clear  in  1  synchronous clear of err_count.
- locked  out  1  high in LOCKED state.
- expected  out  4  value predicted for the most recent beat.
- mismatch  out  1  one-cycle pulse: beat's count differed from prediction.
- range_err  out  1  one-cycle pulse: count > 11, or load with data_in > 11.
- wrap_up  out  1  one-cycle pulse: observed 11 -> 0 on an up step.
- wrap_down  out  1  one-cycle pulse: observed 0 -> 11 on a down step.
- err_count  out  ERR_W  saturating mismatch tally.

## Operation
- Internal state: ref (4 b, last accepted value), miss_run (4 b, consecutive-mismatch count), FSM {UNSYNC, LOCKED}.
- Prediction pred for a beat, priority order:
  - load=1: pred = data_in.
  - mode=0: pred = 0 if ref >= 11, else ref+1.
  - mode=1: pred = 11 if ref == 0 or ref > 11, else ref-1.
- UNSYNC, valid beat:
  - count <= 11: ref <= count, go LOCKED, miss_run <= 0. No comparison and no mismatch.
  - count > 11: range_err pulses, stay UNSYNC.
- LOCKED, valid beat:
  - count == pred: ref <= count, miss_run <= 0.
  - count != pred: mismatch pulses, err_count increments, ref <= count (resync, so one fault costs one error), miss_run increments.
  - If miss_run reaches LOSS_THRESH, go UNSYNC on that beat and clear miss_run.
- range_err pulses whenever count > 11, or whenever load=1 with data_in > 11. A single beat produces a single pulse even if both conditions hold. In LOCKED, such a beat is also compared normally.
- Wrap pulses, LOCKED only, on a matching, non-load beat:
  - wrap_up: mode=0, ref=11, count=0.
  - wrap_down: mode=1, ref=0, count=11.
- expected <= pred on every LOCKED valid beat. In UNSYNC, expected <= count.
- err_count:
  - Saturates at 2^ERR_W-1.
  - err_clear alone sets it to 0.
  - err_clear together with a mismatch sets it to 1.
- valid=0: no state change, all pulses low, expected and err_count hold.

## Timing
- All outputs are registered and respond on the clock edge after the valid beat is sampled; latency is 1 cycle.
- Back-to-back beats are fully supported at one beat per cycle, with no stall.
- Reset values:
  - State: UNSYNC, ref=0, miss_run=0.
  - Outputs: locked=0, expected=0, mismatch=0, range_err=0, wrap_up=0, wrap_down=0, err_count=0.
- Reset asserted mid-stream discards ref. The first valid beat after reset deasserts re-acquires lock, and that beat never pulses mismatch.
- locked rises 1 cycle after the acquiring beat. It falls 1 cycle after the beat that reaches LOSS_THRESH; that beat also pulses mismatch.
- Reset has priority over err_clear and valid.

## Test plan
- Acquire and up-count: after reset, beats count=9, then up 10, 11, 0, 1 -> locked=1 from the 2nd output cycle; wrap_up pulses once on the 11->0 beat; no mismatch; err_count=0.
- Down wrap and load: locked at 1, down beats 0, 11, 10, then load data_in=5 with count=5, then mode=1 with count=5 -> wrap_down on the 0->11 beat; the final beat gives mismatch (pred 4) and err_count=1.
- Loss of lock: LOSS_THRESH=3, locked at 4, three up beats with count=7, 2, 9 -> mismatch pulses three times, err_count=3, locked falls after the 3rd beat; next beat count=3 re-locks with no mismatch.
- Range errors: in UNSYNC, count=13 -> range_err, stays unlocked. In LOCKED at 11, load data_in=14 with count=14 -> a single range_err pulse and expected=14; the next up beat predicts 0.
- Saturation and clear: ERR_W=2, force 5 mismatches -> err_count sticks at 3. err_clear together with a mismatch -> err_count=1. err_clear alone -> 0.
- Idle and reset mid-stream: valid low for 10 cycles between beats -> no pulses and outputs hold. Reset while locked -> all outputs zero the next cycle, then re-acquisition on the first beat.
